// File: rtl/aes_encipher_lanes.sv
// ---------------------------------------------------------------------------
// aes_encipher_lanes
// Iterative AES encipher datapath (AES-128/192/256). SubBytes is spread over
// 4/SBOX_LANES cycles per round, using SBOX_LANES 32-bit words of the shared
// S-box bank per cycle. Round keys come from an external key schedule that
// is indexed by the round output.
//
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   next       start request, sampled only while idle
//   abort      synchronous cancel back to idle
//   keylen     0=AES-128, 1=AES-192, 2=AES-256, 3=reserved (rejected)
//   round      current round index for the key schedule
//   round_key  round key belonging to round, valid the same cycle
//   sboxw      words sent to the S-box bank, lane k = bits [32k+31:32k]
//   new_sboxw  substituted words returned combinationally
//   block      plaintext, sampled in the INIT cycle
//   new_block  state register; ciphertext once done has pulsed
//   ready      high while idle
//   done       one-cycle pulse when the ciphertext becomes valid
//   err        one-cycle pulse when a start is rejected for keylen=3
// ---------------------------------------------------------------------------
module aes_encipher_lanes #(
  parameter int SBOX_LANES = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      next,
  input  logic                      abort,
  input  logic [1:0]                keylen,
  output logic [3:0]                round,
  input  logic [127:0]              round_key,
  output logic [32*SBOX_LANES-1:0]  sboxw,
  input  logic [32*SBOX_LANES-1:0]  new_sboxw,
  input  logic [127:0]              block,
  output logic [127:0]              new_block,
  output logic                      ready,
  output logic                      done,
  output logic                      err
);

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
    $error("SBOX_LANES must be 1, 2 or 4");
  end

  localparam int S  = 4 / SBOX_LANES;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

  state_t                     r_state;
  logic [CW-1:0]              r_sword_ctr;
  logic [1:0]                 r_keylen;
  logic [127:0]               r_block;
  logic [3:0]                 r_round;
  logic                       r_ready;
  logic                       r_done;
  logic                       r_err;

  logic [3:0]                 w_nr;
  logic                       w_last_round;
  logic                       w_ctr_last;
  logic [32*SBOX_LANES-1:0]   w_sboxw;
  logic [127:0]               w_sub_block;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24]; a1 = w[23:16]; a2 = w[15:8]; a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++)
      t[127-32*c -: 32] = mix_word(s[127-32*c -: 32]);
    return t;
  endfunction

  // Byte (column c, row r) sits at bits [127-8*(4c+r) -: 8]; row r rotates
  // left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return t;
  endfunction

  always_comb begin
    case (r_keylen)
      2'd1:    w_nr = 4'd12;
      2'd2:    w_nr = 4'd14;
      default: w_nr = 4'd10;
    endcase
  end

  assign w_last_round = (r_round == w_nr);
  assign w_ctr_last   = (r_sword_ctr == CW'(S-1));

  // Lane k handles state word sword_ctr*SBOX_LANES+k; word i is at
  // bits [96-32i +: 32] (w0 is the most significant word).
  always_comb begin
    w_sboxw     = '0;
    w_sub_block = r_block;
    if (r_state == SBOX) begin
      for (int k = 0; k < SBOX_LANES; k++) begin
        w_sboxw[32*k +: 32] = r_block[96-32*(int'(r_sword_ctr)*SBOX_LANES+k) +: 32];
        w_sub_block[96-32*(int'(r_sword_ctr)*SBOX_LANES+k) +: 32] = new_sboxw[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_sword_ctr <= '0;
      r_keylen    <= 2'd0;
      r_block     <= '0;
      r_round     <= 4'd0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (abort && r_state != IDLE) begin
        // Partial state is left in r_block; it is not ciphertext.
        r_state     <= IDLE;
        r_ready     <= 1'b1;
        r_round     <= 4'd0;
        r_sword_ctr <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            // abort in IDLE suppresses a simultaneous start, without err.
            if (next && !abort) begin
              if (keylen == 2'd3) begin
                r_err <= 1'b1;
              end else begin
                r_keylen <= keylen;
                r_round  <= 4'd0;
                r_ready  <= 1'b0;
                r_state  <= INIT;
              end
            end
          end
          INIT: begin
            r_block     <= block ^ round_key;
            r_round     <= 4'd1;
            r_sword_ctr <= '0;
            r_state     <= SBOX;
          end
          SBOX: begin
            r_block <= w_sub_block;
            if (w_ctr_last) begin
              r_sword_ctr <= '0;
              r_state     <= MAIN;
            end else begin
              r_sword_ctr <= r_sword_ctr + 1'b1;
            end
          end
          MAIN: begin
            if (w_last_round) begin
              r_block <= shift_rows(r_block) ^ round_key;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_block <= mix_columns(shift_rows(r_block)) ^ round_key;
              r_round <= r_round + 4'd1;
              r_state <= SBOX;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign round     = r_round;
  assign sboxw     = w_sboxw;
  assign new_block = r_block;
  assign ready     = r_ready;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: doc/aes_encipher_lanes.md
Name: aes_encipher_lanes

Overview:
Iterative AES encipher datapath with a parametrised number of S-box lanes, so SubBytes takes 4/SBOX_LANES cycles per round. Supports AES-128, AES-192 and AES-256. Adds keylen latching, abort, a done pulse and reserved-keylen error reporting. Sits between the core control and the shared key memory and S-box bank. Round keys come from the external key schedule, indexed by `round`.

Parameters:
SBOX_LANES, 1, number of 32-bit S-box words substituted per cycle; legal values 1, 2, 4 (others: elaboration error)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
next  in  1  start request; sampled in IDLE only
abort  in  1  synchronous cancel; returns to IDLE
keylen  in  2  0=AES-128 (10 rounds), 1=AES-192 (12), 2=AES-256 (14), 3=reserved
round  out  4  current round index, used by the key schedule
round_key  in  128  round key for `round`, valid the same cycle
sboxw  out  32*SBOX_LANES  words to the S-box bank; lane k = bits [32k+31:32k]
new_sboxw  in  32*SBOX_LANES  substituted words, combinational return
block  in  128  plaintext; sampled in the INIT cycle
new_block  out  128  state register; holds ciphertext when ready=1 after done
ready  out  1  1 = idle, can accept next
done  out  1  one-cycle pulse when ciphertext becomes valid
err  out  1  one-cycle pulse when next is rejected because keylen=3

Behaviour:
- Reset values: new_block=0, round=0, ready=1, done=0, err=0, FSM=IDLE, sword_ctr=0, keylen_reg=0. sboxw=0 whenever the FSM is not in SBOX.
- State words are w0=new_block[127:96] through w3=new_block[31:0]. S = 4/SBOX_LANES.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - next=1 and keylen!=3: latch keylen into keylen_reg, round<=0, ready<=0, go to INIT.
  - next=1 and keylen=3: stay in IDLE, err<=1 for one cycle.
- INIT:
  - state <= block ^ round_key (round=0 during this cycle).
  - round<=1, sword_ctr<=0, go to SBOX.
- SBOX:
  - Lane k presents word w[sword_ctr*SBOX_LANES+k] on sboxw and writes new_sboxw lane k back into that word.
  - sword_ctr increments each cycle (width log2(S), minimum 1 bit).
  - On sword_ctr=S-1: sword_ctr wraps to 0, go to MAIN.
  - With SBOX_LANES=4 this state lasts exactly one cycle.
- MAIN, with Nr = round count selected by keylen_reg:
  - round<Nr: state <= MixColumns(ShiftRows(state)) ^ round_key; round<=round+1; go to SBOX.
  - round=Nr: state <= ShiftRows(state) ^ round_key; ready<=1; done<=1 (one cycle); go to IDLE. round holds Nr until the next start.
- Latency: from the clock edge that samples next to ready=1 is 1 + Nr*(S+1) cycles.
  - AES-128: 51 cycles at SBOX_LANES=1, 31 at 2, 21 at 4.
  - AES-192 at SBOX_LANES=2: 37 cycles.
  - AES-256 at SBOX_LANES=1: 71 cycles.
- keylen changes after start are ignored; keylen_reg is used for the whole block.
- next while busy (ready=0) is ignored, with no err.
- abort:
  - Busy: next state is IDLE, ready<=1, round<=0, sword_ctr<=0, done stays 0. new_block retains its partial contents, which must not be treated as ciphertext.
  - In IDLE: no effect.
  - Simultaneous with next in IDLE: abort wins, next is dropped, no err.
- A new next in the cycle right after done is legal (back-to-back blocks). new_block then updates at INIT of the following operation.
- reset_n asserted mid-operation clears everything to reset values asynchronously. The first next after release starts cleanly.

Test Plan:
- AES-128, FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff, bench key schedule and S-box models, SBOX_LANES=1/2/4 -> new_block=69c4e0d86a7b0430d8cdb78070b4c55a, done pulse at 51/31/21 cycles after next.
- AES-192, C.2: key 000102..17, same pt, SBOX_LANES=2 -> dda97ca4864cdfe06eaf70a0ec0d7191 after 37 cycles; round walks 0..12.
- AES-256, C.3: key 000102..1f, same pt, SBOX_LANES=1; keylen toggled to 0 mid-operation -> 8ea2b7ca516745bfeafc49904b496089 after 71 cycles, unaffected by the toggle.
- Abort and error paths:
  - abort at round 5 -> ready=1 next cycle, round=0, no done.
  - Immediate restart with the C.1 vector -> correct ciphertext.
  - next with keylen=3 -> err pulse, ready stays 1, round stays 0.
- Back-to-back and reset:
  - Two C.1 encryptions with next asserted the cycle after done -> both correct, second done exactly 51 cycles later.
  - reset_n pulsed mid-SBOX -> all outputs at reset values, sboxw=0.
